// File: rtl/key_pulse_debouncer.sv
// key_pulse_debouncer
//   Turns a raw, bouncing, active-low pushbutton into a debounced level plus
//   single-cycle press/release strobes in the Clk domain. Intended to feed the
//   count enable of the hex counter so that it runs on the board clock.
//
//   Optional feature macro: AUTO_REPEAT_EN
//     defined   -> while held, press_pulse re-fires after REPEAT_DELAY cycles,
//                  then every REPEAT_PERIOD cycles.
//     undefined -> one press_pulse per accepted press, no repeat logic.
//
// Ports:
//   Clk           in   system clock (CLOCK_50)
//   Resetn        in   asynchronous active-low reset
//   key_n         in   raw pushbutton, 0 = pressed, asynchronous to Clk
//   pressed       out  debounced level, 1 while the key is accepted as held
//   press_pulse   out  one-cycle strobe on accepted press (and auto-repeat)
//   release_pulse out  one-cycle strobe on accepted release
module key_pulse_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic Clk,
    input  logic Resetn,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    // Repeat intervals can exceed the debounce range, so the shared counter
    // is widened only when the repeat logic exists.
`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int CW      = (RPT_W > CNT_W) ? RPT_W : CNT_W;
`else
    localparam int CW      = CNT_W;
`endif

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time parameter sanity check.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("key_pulse_debouncer: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        HELD        = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          s1, s2;
    logic          pressed_nxt, press_nxt, release_nxt;
`ifdef AUTO_REPEAT_EN
    // Set once the first (long) repeat delay has elapsed in this hold.
    logic          rep, rep_nxt;
`endif

    // Two-flop synchroniser; reset to the released level.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state         <= IDLE;
            cnt           <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep           <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            pressed       <= pressed_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
`ifdef AUTO_REPEAT_EN
            rep           <= rep_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pressed_nxt = pressed;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_nxt     = rep;
`endif
        case (state)
            IDLE: begin
                if (!s2) begin
                    state_nxt = ARM_PRESS;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            ARM_PRESS: begin
                if (s2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt   = HELD;
                    pressed_nxt = 1'b1;
                    press_nxt   = 1'b1;
                    cnt_nxt     = '0;
`ifdef AUTO_REPEAT_EN
                    rep_nxt     = 1'b0;
`endif
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HELD: begin
                if (s2) begin
                    state_nxt = ARM_RELEASE;
                    cnt_nxt   = CW'(1);
                end else begin
`ifdef AUTO_REPEAT_EN
                    // cnt counts held cycles; terminal value depends on
                    // whether the first repeat has already fired.
                    if (cnt == (rep ? CW'(REPEAT_PERIOD - 1) : CW'(REPEAT_DELAY - 1))) begin
                        press_nxt = 1'b1;
                        cnt_nxt   = '0;
                        rep_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
`else
                    cnt_nxt = cnt;
`endif
                end
            end
            ARM_RELEASE: begin
                if (!s2) begin
                    // Bounce back: repeat timing restarts from REPEAT_DELAY.
                    state_nxt = HELD;
                    cnt_nxt   = '0;
`ifdef AUTO_REPEAT_EN
                    rep_nxt   = 1'b0;
`endif
                end else if (cnt == DB_LAST) begin
                    state_nxt   = IDLE;
                    pressed_nxt = 1'b0;
                    release_nxt = 1'b1;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_pulse_debouncer.sv
// Bench for key_pulse_debouncer with DEBOUNCE_CYCLES=8, REPEAT_DELAY=32,
// REPEAT_PERIOD=16. Stimulus pushes expected strobes (kind + cycle) into a
// queue; an independent monitor pops and compares whenever a strobe appears.
// Inputs are driven and outputs sampled on the falling edge; "cyc" holds the
// number of rising edges seen so far.
module tb_key_pulse_debouncer;

    localparam int DB = 8;
    localparam int RD = 32;
    localparam int RP = 16;

    logic Clk = 1'b0;
    logic Resetn;
    logic key_n;
    logic pressed, press_pulse, release_pulse;

    key_pulse_debouncer #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(6),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .Clk(Clk),
        .Resetn(Resetn),
        .key_n(key_n),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        bit rel;
        int at;
    } ev_t;

    ev_t sbq[$];
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cyc %0d: got %0b expected %0b", name, cyc, act, exp);
        end
    endtask

    task automatic push(input bit rel, input int at);
        ev_t e;
        e.rel = rel;
        e.at  = at;
        sbq.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge Clk);
    endtask

    // Monitor: every strobe must match the head of the scoreboard; an expected
    // strobe whose cycle has passed without appearing is reported as missed.
    always @(negedge Clk) begin
        if (press_pulse || release_pulse) begin
            tests++;
            if (press_pulse && release_pulse) begin
                fails++;
                $display("FAIL both_strobes at cyc %0d", cyc);
            end else if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe at cyc %0d: got rel=%0b, none expected",
                         cyc, release_pulse);
            end else begin
                ev_t e;
                e = sbq.pop_front();
                if (e.rel != release_pulse || e.at != cyc) begin
                    fails++;
                    $display("FAIL strobe at cyc %0d rel=%0b: expected rel=%0b at cyc %0d",
                             cyc, release_pulse, e.rel, e.at);
                end
            end
        end else if (sbq.size() != 0 && sbq[0].at < cyc) begin
            ev_t e;
            e = sbq.pop_front();
            tests++;
            fails++;
            $display("FAIL missed_strobe rel=%0b: expected at cyc %0d, none by cyc %0d",
                     e.rel, e.at, cyc);
        end
    end

    // Drives key low now, holds for 'hold' cycles past the accept, releases.
    task automatic press_release(input int hold);
        int a, r;
        a = cyc + DB + 2;
        r = a + hold;
        key_n = 1'b0;
        push(1'b0, a);
`ifdef AUTO_REPEAT_EN
        for (int t = RD; a + t <= r + 1; t += RP) push(1'b0, a + t);
`endif
        push(1'b1, r + DB + 2);
        wait_until(a - 1);
        chk("pressed_before_accept", pressed, 1'b0);
        wait_until(a + 2);
        chk("pressed_after_accept", pressed, 1'b1);
        wait_until(r);
        key_n = 1'b1;
        wait_until(r + DB + 1);
        chk("pressed_before_release", pressed, 1'b1);
        wait_until(r + DB + 4);
        chk("pressed_after_release", pressed, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, f;
        Resetn = 1'b0;
        key_n  = 1'b0;

        // Reset with key held low.
        repeat (3) @(negedge Clk);
        chk("rst_pressed", pressed, 1'b0);
        chk("rst_press_pulse", press_pulse, 1'b0);
        chk("rst_release_pulse", release_pulse, 1'b0);
        Resetn = 1'b1;
        press_release(20);          // key already low: accept 10 cycles after release

        // Clean press, long hold.
        repeat (5) @(negedge Clk);
        press_release(40);

        // Bounce: short lows never accepted.
        repeat (5) @(negedge Clk);
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0;
            repeat (3) @(negedge Clk);
            key_n = 1'b1;
            repeat (2) @(negedge Clk);
            chk("bounce_pressed", pressed, 1'b0);
        end
        repeat (20) @(negedge Clk);
        chk("bounce_pressed_end", pressed, 1'b0);

        // Release with a low glitch before settling high.
        a = cyc + DB + 2;
        key_n = 1'b0;
        push(1'b0, a);
        wait_until(a + 5);
        key_n = 1'b1;
        repeat (3) @(negedge Clk);
        key_n = 1'b0;
        repeat (4) @(negedge Clk);
        key_n = 1'b1;
        f = cyc;
        push(1'b1, f + DB + 2);
        wait_until(f + 5);
        chk("glitch_still_pressed", pressed, 1'b1);
        wait_until(f + DB + 4);
        chk("glitch_released", pressed, 1'b0);

        // Reset during ARM_PRESS with counter at 5.
        repeat (5) @(negedge Clk);
        a = cyc;
        key_n = 1'b0;
        wait_until(a + 7);
        Resetn = 1'b0;
        #1;
        chk("midarm_rst_pressed", pressed, 1'b0);
        repeat (2) @(negedge Clk);
        Resetn = 1'b1;
        press_release(15);          // full latency again after reset

        // Reset during HELD: no release strobe.
        repeat (5) @(negedge Clk);
        a = cyc + DB + 2;
        key_n = 1'b0;
        push(1'b0, a);
        wait_until(a + 5);
        chk("midheld_pressed", pressed, 1'b1);
        Resetn = 1'b0;
        #1;
        chk("midheld_rst_pressed", pressed, 1'b0);
        key_n = 1'b1;
        repeat (3) @(negedge Clk);
        Resetn = 1'b1;
        repeat (20) @(negedge Clk);
        chk("midheld_after_pressed", pressed, 1'b0);
        press_release(15);

        // Long hold: auto-repeat strobes when the feature is built in.
        repeat (5) @(negedge Clk);
        press_release(100);

        repeat (30) @(negedge Clk);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expected strobes left, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
